// File: rtl/mmio_pkg.sv
// Shared AXI4-Lite response encoding for the MMIO register file.
package mmio_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mmio_strb_merge.sv
// Byte-strobe merge: each enabled byte lane takes new data, the rest keep old data.
module mmio_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb_i[b]) merged_o[b*8 +: 8] = new_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/mmio_regfile.sv
// AXI4-Lite slave register file with RW control and RO status registers.
// Optional wr_pulse output enabled by defining MMIO_REGFILE_WR_PULSE_EN.
module mmio_regfile
  import mmio_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          axi_mmio_awaddr,
  input  logic [2:0]                     axi_mmio_awprot,
  input  logic                           axi_mmio_awvalid,
  output logic                           axi_mmio_awready,
  input  logic [DATA_WIDTH-1:0]          axi_mmio_wdata,
  input  logic [DATA_WIDTH/8-1:0]        axi_mmio_wstrb,
  input  logic                           axi_mmio_wvalid,
  output logic                           axi_mmio_wready,
  output logic [1:0]                     axi_mmio_bresp,
  output logic                           axi_mmio_bvalid,
  input  logic                           axi_mmio_bready,
  input  logic [ADDR_WIDTH-1:0]          axi_mmio_araddr,
  input  logic [2:0]                     axi_mmio_arprot,
  input  logic                           axi_mmio_arvalid,
  output logic                           axi_mmio_arready,
  output logic [DATA_WIDTH-1:0]          axi_mmio_rdata,
  output logic [1:0]                     axi_mmio_rresp,
  output logic                           axi_mmio_rvalid,
  input  logic                           axi_mmio_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
`ifdef MMIO_REGFILE_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]            wr_pulse
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IW     = ADDR_WIDTH - LSB;

  typedef logic [IW-1:0] idx_t;

  // A transfer happens on the rising edge where valid and ready are both high.
  // Every valid/ready/resp/data output comes straight from a flop, so no valid
  // ever depends combinationally on a ready input.

  logic                  aw_full_q, aw_full_d;
  idx_t                  aw_idx_q;
  logic                  aw_err_q, aw_err_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q, bvalid_d;
  logic                  done_q, done_d;
  axi_resp_t             bresp_q;
  logic                  rvalid_q;
  axi_resp_t             rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  idx_t                  aw_in_idx, ar_idx;
  logic                  aw_in_ro, aw_in_err, ar_err;
  logic [DATA_WIDTH-1:0] old_val, rd_val, merged;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  commit, commit_ok;

  assign aw_in_idx = axi_mmio_awaddr[ADDR_WIDTH-1:LSB];
  assign ar_idx    = axi_mmio_araddr[ADDR_WIDTH-1:LSB];

  assign aw_hs = axi_mmio_awvalid & ~aw_full_q;
  assign w_hs  = axi_mmio_wvalid & ~w_full_q;
  assign b_hs  = bvalid_q & axi_mmio_bready;
  assign ar_hs = axi_mmio_arvalid & ~rvalid_q;
  assign r_hs  = rvalid_q & axi_mmio_rready;

  always_comb begin
    aw_in_ro = 1'b0;
    old_val  = '0;
    rd_val   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_in_idx == idx_t'(i)) aw_in_ro = RO_MASK[i];
      if (aw_idx_q == idx_t'(i)) old_val = regs_q[i];
      if (ar_idx == idx_t'(i)) begin
        rd_val = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  assign aw_in_err = (aw_in_idx >= idx_t'(NUM_REGS)) | aw_in_ro;
  assign ar_err    = (ar_idx >= idx_t'(NUM_REGS));

  // Buffers stay full through the B response; that alone blocks new AW/W.
  assign aw_full_d = b_hs ? 1'b0 : (aw_full_q | aw_hs);
  assign w_full_d  = b_hs ? 1'b0 : (w_full_q | w_hs);
  assign aw_err_d  = aw_hs ? aw_in_err : aw_err_q;
  assign bvalid_d  = aw_full_d & w_full_d;

  // The write commits in the first cycle its response is visible; done_q
  // keeps a stalled response from committing again.
  assign commit    = bvalid_q & ~done_q;
  assign commit_ok = commit & ~aw_err_q;
  assign done_d    = b_hs ? 1'b0 : (done_q | commit);

  mmio_strb_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_strb_merge (
    .old_i   (old_val),
    .new_i   (w_data_q),
    .strb_i  (w_strb_q),
    .merged_o(merged)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_err_q  <= aw_err_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      done_q    <= done_d;
      if (aw_hs) aw_idx_q <= aw_in_idx;
      if (w_hs) begin
        w_data_q <= axi_mmio_wdata;
        w_strb_q <= axi_mmio_wstrb;
      end
      if (b_hs) begin
        bresp_q <= RESP_OKAY;
      end else if (!bvalid_q && bvalid_d) begin
        bresp_q <= aw_err_d ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= ar_err ? RESP_SLVERR : RESP_OKAY;
      rdata_q  <= ar_err ? '0 : rd_val;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

  // Reads sample regs_q before this edge, so a colliding read sees the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (aw_idx_q == idx_t'(i) && !RO_MASK[i]) regs_q[i] <= merged;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
    assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
  end

`ifdef MMIO_REGFILE_WR_PULSE_EN
  always_comb begin
    wr_pulse = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit_ok && aw_idx_q == idx_t'(i)) wr_pulse[i] = 1'b1;
    end
  end
`endif

  assign axi_mmio_awready = ~aw_full_q;
  assign axi_mmio_wready  = ~w_full_q;
  assign axi_mmio_bvalid  = bvalid_q;
  assign axi_mmio_bresp   = bresp_q;
  assign axi_mmio_arready = ~rvalid_q;
  assign axi_mmio_rvalid  = rvalid_q;
  assign axi_mmio_rresp   = rresp_q;
  assign axi_mmio_rdata   = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{axi_mmio_awprot, axi_mmio_arprot,
                       axi_mmio_awaddr[LSB-1:0], axi_mmio_araddr[LSB-1:0]};

endmodule

// File: tb/tb_mmio_regfile.sv
// Directed testbench for mmio_regfile (32-bit, 16 registers, register 3 read-only).
// Also covers wr_pulse when built with MMIO_REGFILE_WR_PULSE_EN.
module tb_mmio_regfile;

  localparam int TMO = 50;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [31:0]   araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [511:0]  ctrl_out;
  logic [511:0]  status_in = '0;
`ifdef MMIO_REGFILE_WR_PULSE_EN
  logic [15:0]   wr_pulse;
`endif

  int            checks = 0;
  int            failures = 0;
  logic [31:0]   exp_regs [16];
  logic [31:0]   exp_q [$];

  always #5 aclk = ~aclk;

  mmio_regfile #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .NUM_REGS  (16),
    .RO_MASK   (16'h0008)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .axi_mmio_awaddr (awaddr),
    .axi_mmio_awprot (awprot),
    .axi_mmio_awvalid(awvalid),
    .axi_mmio_awready(awready),
    .axi_mmio_wdata  (wdata),
    .axi_mmio_wstrb  (wstrb),
    .axi_mmio_wvalid (wvalid),
    .axi_mmio_wready (wready),
    .axi_mmio_bresp  (bresp),
    .axi_mmio_bvalid (bvalid),
    .axi_mmio_bready (bready),
    .axi_mmio_araddr (araddr),
    .axi_mmio_arprot (arprot),
    .axi_mmio_arvalid(arvalid),
    .axi_mmio_arready(arready),
    .axi_mmio_rdata  (rdata),
    .axi_mmio_rresp  (rresp),
    .axi_mmio_rvalid (rvalid),
    .axi_mmio_rready (rready),
    .ctrl_out        (ctrl_out),
    .status_in       (status_in)
`ifdef MMIO_REGFILE_WR_PULSE_EN
    ,
    .wr_pulse        (wr_pulse)
`endif
  );

  function automatic logic [511:0] exp_ctrl();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = exp_regs[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic timeout_fail(input string what);
    checks++;
    failures++;
    $display("FAIL timeout_%s: no handshake within %0d cycles", what, TMO);
  endtask

  // Driver tasks
  task automatic aw_send(input logic [31:0] a);
    int n = 0;
    awaddr  = a;
    awvalid = 1'b1;
    while (!awready && n < TMO) begin tick(); n++; end
    if (n >= TMO) timeout_fail("aw");
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    while (!wready && n < TMO) begin tick(); n++; end
    if (n >= TMO) timeout_fail("w");
    tick();
    wvalid = 1'b0;
  endtask

  task automatic b_take(output logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < TMO) begin tick(); n++; end
    if (n >= TMO) timeout_fail("b");
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    int n = 0;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    while (!(awready && wready) && n < TMO) begin tick(); n++; end
    if (n >= TMO) timeout_fail("aw_w");
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    b_take(resp);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    int n = 0;
    araddr  = a;
    arvalid = 1'b1;
    while (!arready && n < TMO) begin tick(); n++; end
    if (n >= TMO) timeout_fail("ar");
    tick();
    arvalid = 1'b0;
    rready  = 1'b1;
    n = 0;
    while (!rvalid && n < TMO) begin tick(); n++; end
    if (n >= TMO) timeout_fail("r");
    d    = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_ready: got aw/w/ar=%b expected 111", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid} !== 2'b00 || bresp !== 2'b00 || rresp !== 2'b00) begin
      failures++;
      $display("FAIL reset_resp: got bvalid=%b rvalid=%b bresp=%0d rresp=%0d expected all 0",
               bvalid, rvalid, bresp, rresp);
    end
    checks++;
    if (rdata !== 32'h0 || ctrl_out !== 512'h0) begin
      failures++;
      $display("FAIL reset_data: got rdata=%h ctrl_out=%h expected 0", rdata, ctrl_out);
    end
  endtask

  task automatic test_aw_first();
    logic [31:0] d;
    logic [1:0]  r;
    aw_send(32'h8);
    repeat (3) tick();
    w_send(32'hDEADBEEF, 4'hF);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
      failures++;
      $display("FAIL aw_first_b: got bvalid=%b bresp=%0d awready=%b wready=%b expected 1,0,0,0",
               bvalid, bresp, awready, wready);
    end
    checks++;
    if (ctrl_out[2*32 +: 32] !== 32'h0) begin
      failures++;
      $display("FAIL aw_first_early: got reg2=%h expected 00000000 before commit", ctrl_out[2*32 +: 32]);
    end
    b_take(r);
    exp_regs[2] = 32'hDEADBEEF;
    checks++;
    if (ctrl_out !== exp_ctrl()) begin
      failures++;
      $display("FAIL aw_first_ctrl: got %h expected %h", ctrl_out, exp_ctrl());
    end
    do_read(32'h8, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      failures++;
      $display("FAIL aw_first_read: got %h/%0d expected deadbeef/0", d, r);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] r;
    do_write(32'h4, 32'hFFFFFFFF, 4'hF, r);
    w_send(32'h12345678, 4'b0101);
    repeat (2) tick();
    aw_send(32'h4);
    b_take(r);
    exp_regs[1] = 32'hFF34FF78;
    checks++;
    if (r !== 2'b00 || ctrl_out !== exp_ctrl()) begin
      failures++;
      $display("FAIL w_first: got bresp=%0d reg1=%h expected 0/ff34ff78", r, ctrl_out[32 +: 32]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(32'h40, 32'h11111111, 4'hF, r);
    checks++;
    if (r !== 2'b10 || ctrl_out !== exp_ctrl()) begin
      failures++;
      $display("FAIL oor_write: got bresp=%0d ctrl=%h expected 2 and unchanged", r, ctrl_out);
    end
    do_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      failures++;
      $display("FAIL oor_read: got %h/%0d expected 0/2", d, r);
    end
    do_write(32'hC, 32'hFFFFFFFF, 4'hF, r);
    checks++;
    if (r !== 2'b10 || ctrl_out !== exp_ctrl()) begin
      failures++;
      $display("FAIL ro_write: got bresp=%0d ctrl=%h expected 2 and unchanged", r, ctrl_out);
    end
    status_in[3*32 +: 32] = 32'hA5;
    status_in[2*32 +: 32] = 32'h77777777;
    do_read(32'hC, d, r);
    checks++;
    if (d !== 32'hA5 || r !== 2'b00) begin
      failures++;
      $display("FAIL ro_read: got %h/%0d expected a5/0", d, r);
    end
    do_read(32'h8, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      failures++;
      $display("FAIL rw_ignores_status: got %h/%0d expected deadbeef/0", d, r);
    end
  endtask

  task automatic test_zero_strobe();
    logic [1:0] r;
    do_write(32'h8, 32'h0, 4'h0, r);
    checks++;
    if (r !== 2'b00 || ctrl_out !== exp_ctrl()) begin
      failures++;
      $display("FAIL zero_strobe: got bresp=%0d reg2=%h expected 0/deadbeef", r, ctrl_out[2*32 +: 32]);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    awaddr  = 32'h10;
    wdata   = 32'hCAFEF00D;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    exp_regs[4] = 32'hCAFEF00D;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      awvalid = 1'b1;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) bad++;
      tick();
    end
    awvalid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b_stall: %0d unstable cycles, expected 0", bad);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || ctrl_out !== exp_ctrl()) begin
      failures++;
      $display("FAIL b_release: got bvalid=%b awready=%b reg4=%h expected 0,1,cafef00d",
               bvalid, awready, ctrl_out[4*32 +: 32]);
    end
    araddr  = 32'hC;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) status_in[3*32 +: 32] = 32'h5A;
      arvalid = 1'b1;
      if (rvalid !== 1'b1 || rdata !== 32'hA5 || rresp !== 2'b00 || arready !== 1'b0) bad++;
      tick();
    end
    arvalid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL r_stall: %0d unstable cycles, expected 0", bad);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++;
      $display("FAIL r_release: got rvalid=%b arready=%b expected 0,1", rvalid, arready);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(32'h4, 32'h1, 4'hF, r);
    awaddr  = 32'h4;
    wdata   = 32'h2;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    araddr  = 32'h4;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1) begin
      failures++;
      $display("FAIL same_cycle_read: got rvalid=%b rdata=%h expected 1/00000001", rvalid, rdata);
    end
    bready = 1'b1;
    rready = 1'b1;
    tick();
    bready = 1'b0;
    rready = 1'b0;
    exp_regs[1] = 32'h2;
    do_read(32'h4, d, r);
    checks++;
    if (d !== 32'h2 || r !== 2'b00) begin
      failures++;
      $display("FAIL same_cycle_next: got %h/%0d expected 00000002/0", d, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    logic [31:0] d, e;
    logic [1:0]  r;
    vals[0] = 32'h70707070;
    vals[1] = 32'h80808080;
    vals[2] = 32'h90909090;
    bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      aw_send(32'((7 + i) * 4));
      w_send(vals[i], 4'hF);
      exp_q.push_back(vals[i]);
      exp_regs[7 + i] = vals[i];
    end
    tick();
    bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_read(32'((7 + i) * 4), d, r);
      e = exp_q.pop_front();
      checks++;
      if (d !== e || r !== 2'b00) begin
        failures++;
        $display("FAIL b2b_read%0d: got %h/%0d expected %h/0", i, d, r, e);
      end
    end
  endtask

`ifdef MMIO_REGFILE_WR_PULSE_EN
  task automatic test_wr_pulse();
    logic [1:0] r;
    awaddr  = 32'h14;
    wdata   = 32'h5;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    checks++;
    if (wr_pulse !== 16'h0020) begin
      failures++;
      $display("FAIL wr_pulse_on: got %h expected 0020", wr_pulse);
    end
    tick();
    checks++;
    if (wr_pulse !== 16'h0000) begin
      failures++;
      $display("FAIL wr_pulse_off: got %h expected 0000", wr_pulse);
    end
    b_take(r);
    exp_regs[5] = 32'h5;
    aw_send(32'h18);
    w_send(32'h0, 4'h0);
    checks++;
    if (wr_pulse !== 16'h0040) begin
      failures++;
      $display("FAIL wr_pulse_zero_strb: got %h expected 0040", wr_pulse);
    end
    b_take(r);
    aw_send(32'hC);
    w_send(32'h1, 4'hF);
    checks++;
    if (wr_pulse !== 16'h0000) begin
      failures++;
      $display("FAIL wr_pulse_ro: got %h expected 0000", wr_pulse);
    end
    b_take(r);
  endtask
`endif

  task automatic test_reset_mid();
    int bad;
    awaddr  = 32'h14;
    wdata   = 32'h55;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    araddr  = 32'h8;
    arvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    #3;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100 || bresp !== 2'b00 ||
        rresp !== 2'b00 || rdata !== 32'h0 || ctrl_out !== 512'h0) begin
      failures++;
      $display("FAIL async_reset: got rdy=%b%b%b bv=%b rv=%b rdata=%h ctrl=%h expected reset values",
               awready, wready, arready, bvalid, rvalid, rdata, ctrl_out);
    end
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    bready = 1'b1;
    rready = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bvalid !== 1'b0 || rvalid !== 1'b0) bad++;
    end
    bready = 1'b0;
    rready = 1'b0;
    checks++;
    if (bad != 0 || ctrl_out !== exp_ctrl()) begin
      failures++;
      $display("FAIL post_reset: %0d cycles with a response, ctrl=%h expected none and 0", bad, ctrl_out);
    end
  endtask

  initial begin
    test_reset();
    test_aw_first();
    test_w_first();
    test_errors();
    test_zero_strobe();
    test_backpressure();
    test_same_cycle();
    test_back_to_back();
`ifdef MMIO_REGFILE_WR_PULSE_EN
    test_wr_pulse();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_regfile.md
# mmio_regfile

Parametrised AXI4-Lite slave register file that terminates the `axi_mmio` channel of a role region. It provides `NUM_REGS` software-visible registers of `DATA_WIDTH` bits. Read/write control registers drive the role logic; read-only status registers sample role inputs. It replaces a hand-written fixed 32-bit MMIO stub with a generic, error-reporting, byte-strobed implementation.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bus and register width; legal values are 32 and 64.
- `ADDR_WIDTH`, 32: width of `axi_mmio_awaddr` / `axi_mmio_araddr`.
- `NUM_REGS`, 16: register count, 1..256.
- `RO_MASK`, 0: `NUM_REGS`-bit vector; bit i set means register i is read-only and returns `status_in` slice i.

Ports (`NUM_REGS*DATA_WIDTH` is written `N*D` below):
- `aclk` in 1: the single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `axi_mmio_awaddr` in ADDR_WIDTH, `axi_mmio_awprot` in 3 (ignored), `axi_mmio_awvalid` in 1, `axi_mmio_awready` out 1.
- `axi_mmio_wdata` in DATA_WIDTH, `axi_mmio_wstrb` in DATA_WIDTH/8, `axi_mmio_wvalid` in 1, `axi_mmio_wready` out 1.
- `axi_mmio_bresp` out 2, `axi_mmio_bvalid` out 1, `axi_mmio_bready` in 1.
- `axi_mmio_araddr` in ADDR_WIDTH, `axi_mmio_arprot` in 3 (ignored), `axi_mmio_arvalid` in 1, `axi_mmio_arready` out 1.
- `axi_mmio_rdata` out DATA_WIDTH, `axi_mmio_rresp` out 2, `axi_mmio_rvalid` out 1, `axi_mmio_rready` in 1.
- `ctrl_out` out N*D: register i is `[i*D +: D]`. RO slots drive 0.
- `status_in` in N*D: sampled for RO registers only.

## Operation
- Register index: `addr[ADDR_WIDTH-1 : log2(D/8)]`. Low address bits are ignored.
- Write address and write data are accepted independently, in either order, and each is held in its own one-entry buffer. The write commits in the cycle both buffers are full and no B response is outstanding.
- Committed write updates only the bytes enabled by `wstrb`. An all-zero strobe is legal and writes nothing; response is OKAY.
- Write response codes:
  - OKAY (2'b00): in-range RW register.
  - SLVERR (2'b10): index >= NUM_REGS, or the target is RO. State is unchanged.
- Read:
  - In-range RW register: returns current register value, OKAY.
  - RO register: returns `status_in` slice as registered at the AR handshake cycle, OKAY.
  - Out-of-range index: returns 0, SLVERR.
- Read and write are independent. If a read handshake and a write commit target the same register in the same cycle, the read returns the pre-write value.

## Timing
- Reset values: all registers 0, `awready`=1, `wready`=1, `arready`=1, `bvalid`=0, `rvalid`=0, `bresp`=0, `rresp`=0, `rdata`=0.
- `awready` is high iff the AW buffer is empty. `wready` is high iff the W buffer is empty.
- Write commit occurs the cycle after the later of the AW and W handshakes. `bvalid` rises in the same cycle as the commit. The register value is visible on `ctrl_out` the cycle after the commit.
- `bvalid` holds until `bready`. Both buffers clear on the B handshake. Back-to-back writes therefore achieve one per 2 cycles when `bready` is held high.
- `arready` = `!rvalid`. `rvalid` and registered `rdata` appear 1 cycle after the AR handshake and hold, stable, until `rready`. Sustained read throughput is one per 2 cycles.
- `valid` outputs never depend combinationally on `ready` inputs.
- `aresetn` asserted mid-transaction drops all pending responses and buffers immediately; there is no completion after release.

## Configuration
- `MMIO_REGFILE_WR_PULSE_EN`:
  - Defined: adds output `wr_pulse` (NUM_REGS bits). Bit i is high for exactly one cycle, coincident with the commit of any write to in-range RW register i, including an all-zero strobe. Reset value is 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `mmio_pkg` holds the response constants (`RESP_OKAY`, `RESP_SLVERR`) and the `axi_resp_t` 2-bit typedef.
- Sub-module `mmio_strb_merge`: combinational byte-strobe merge of old data, new data and `wstrb`, parametrised on `DATA_WIDTH`.
- All channel logic lives in the top module.

## Test plan
- AW then W 3 cycles later, addr 0x8, data 0xDEADBEEF, strb 0xF → `bresp`=0. `ctrl_out` reg 2 reads 0xDEADBEEF; a subsequent read of 0x8 returns 0xDEADBEEF, OKAY.
- W before AW, addr 0x4, data 0x12345678, strb 4'b0101, prior value 0xFFFFFFFF → register becomes 0xFF34FF78.
- Out-of-range and RO access, with `NUM_REGS`=16 and `RO_MASK` bit 3 set:
  - Write to 0x40 → SLVERR, no register changes.
  - Read of 0x40 → `rdata`=0, SLVERR.
  - Write to 0xC → SLVERR.
  - Read of 0xC with `status_in` slice 3 = 0xA5 → 0xA5, OKAY.
- Backpressure: hold `bready`/`rready` low for 5 cycles → `bvalid`/`rvalid` and data remain stable, and `awready`/`wready`/`arready` stay low until the response handshake.
- Same-cycle read and write commit on reg 1 (old 0x1, new 0x2) → read returns 0x1; the next read returns 0x2.
- Assert `aresetn` with AW buffered and `bvalid`=1 → all outputs take their reset values asynchronously, with no B response after release. With `MMIO_REGFILE_WR_PULSE_EN` defined, a write to reg 5 gives `wr_pulse`=0x20 for one cycle.
